// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits are combinational. A miss
// refills the whole line in ascending word order over a request/ready bus.
module icache #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] program_counter_address,
  output logic [31:0] instruction,
  output logic        instruction_grant,
  input  logic        invalidate,
  output logic        mem_read_enable,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 32 - OB - IB - 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e            state_q, state_d;
  logic [OB-1:0]     cnt_q, cnt_d;
  logic              inval_pending_q, inval_pending_d;
  logic [31:0]       refill_base_q, refill_base_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]     tag_q  [NUM_LINES];
  logic [31:0]       data_q [NUM_LINES][WORDS_PER_LINE];

  logic [OB-1:0] pc_offset;
  logic [IB-1:0] pc_index;
  logic [TW-1:0] pc_tag;
  logic [IB-1:0] refill_index;
  logic          hit, word_done, last_word;
  logic          unused_pc_bits;

  assign pc_offset      = program_counter_address[OB+1:2];
  assign pc_index       = program_counter_address[OB+IB+1:OB+2];
  assign pc_tag         = program_counter_address[31:OB+IB+2];
  assign unused_pc_bits = ^program_counter_address[1:0];
  assign refill_index   = refill_base_q[OB+IB+1:OB+2];

  assign hit               = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign instruction_grant = hit;
  assign instruction       = hit ? data_q[pc_index][pc_offset] : NOP;

  assign word_done       = (state_q == REFILL) && mem_ready;
  assign last_word       = word_done && (&cnt_q);
  assign mem_read_enable = (state_q == REFILL);
  assign mem_address     = (state_q == REFILL) ? refill_base_q + 32'({cnt_q, 2'b00}) : 32'h0;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    inval_pending_d = inval_pending_q;
    refill_base_d   = refill_base_q;
    valid_d         = valid_q;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          refill_base_d     = {program_counter_address[31:OB+2], {(OB+2){1'b0}}};
          cnt_d             = '0;
          // The evicted line must not hit on its old tag while being overwritten.
          valid_d[pc_index] = 1'b0;
          state_d           = REFILL;
        end
      end
      REFILL: begin
        if (invalidate) inval_pending_d = 1'b1;
        if (word_done) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            valid_d[refill_index] = !inval_pending_q && !invalidate;
            inval_pending_d       = 1'b0;
            state_d               = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (invalidate) valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      inval_pending_q <= 1'b0;
      refill_base_q   <= '0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inval_pending_q <= inval_pending_d;
      refill_base_q   <= refill_base_d;
      valid_q         <= valid_d;
    end
  end

  // NOTE: data and tag storage have no reset; valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (word_done) data_q[refill_index][cnt_q] <= mem_read_data;
    if (last_word) tag_q[refill_index] <= refill_base_q[31:OB+IB+2];
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a hit-vector table plus hand-written refill
// sequences (cold miss, conflict, stalls, invalidate, PC change, reset).
module tb_icache;

  localparam int WPL = 4;
  localparam int NL  = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_i = 32'h100;
  logic [31:0] instruction;
  logic        instruction_grant;
  logic        invalidate = 1'b0;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_read_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cycles = 0;
  int wait_cnt = 0;
  logic hold_q = 1'b0;
  logic [31:0] held_addr = '0;
  logic [31:0] addr_log[$];

  icache #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .program_counter_address (pc_i),
    .instruction             (instruction),
    .instruction_grant       (instruction_grant),
    .invalidate              (invalidate),
    .mem_read_enable         (mem_read_enable),
    .mem_address             (mem_address),
    .mem_ready               (mem_ready),
    .mem_read_data           (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x100 -> 0xA0, 0x104 -> 0xA1, ...
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Memory responder: stalls stall_cycles cycles before each word, checks the request holds.
  always @(negedge clk) begin
    if (hold_q) begin
      check("stall_en_hold", {31'b0, mem_read_enable}, 32'h1);
      check("stall_addr_hold", mem_address, held_addr);
    end
    hold_q = 1'b0;
    if (rst_n && mem_read_enable) begin
      if (wait_cnt >= stall_cycles) begin
        mem_ready     = 1'b1;
        mem_read_data = mem_data(mem_address);
        addr_log.push_back(mem_address);
        wait_cnt      = 0;
      end else begin
        mem_ready     = 1'b0;
        mem_read_data = '0;
        wait_cnt++;
        hold_q    = 1'b1;
        held_addr = mem_address;
      end
    end else begin
      mem_ready     = 1'b0;
      mem_read_data = '0;
      wait_cnt      = 0;
    end
  end

  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    while (!instruction_grant && cycles < budget) begin
      @(negedge clk); #1;
      cycles++;
    end
  endtask

  task automatic wait_mem_idle(input int budget, input string name);
    int n = 0;
    while (mem_read_enable && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("%s refill_done", name), {31'b0, mem_read_enable}, 32'h0);
  endtask

  // Called in the miss cycle (PC already presented): checks latency, data and address order.
  task automatic finish_miss(input logic [31:0] pc, input int exp_cycles, input string name);
    int cycles;
    logic [31:0] base;
    check($sformatf("%s miss_grant", name), {31'b0, instruction_grant}, 32'h0);
    check($sformatf("%s miss_nop", name), instruction, NOP);
    addr_log.delete();
    wait_grant(200, cycles);
    check($sformatf("%s latency", name), cycles, exp_cycles);
    check($sformatf("%s data", name), instruction, mem_data({pc[31:2], 2'b00}));
    base = {pc[31:4], 4'h0};
    check($sformatf("%s n_words", name), addr_log.size(), WPL);
    for (int i = 0; i < WPL && i < addr_log.size(); i++)
      check($sformatf("%s addr%0d", name, i), addr_log[i], base + 32'(4 * i));
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input int exp_cycles, input string name);
    @(negedge clk); pc_i = pc; #1;
    finish_miss(pc, exp_cycles, name);
  endtask

  task automatic check_line(input logic [31:0] base, input string name);
    for (int i = 0; i < WPL; i++) begin
      @(negedge clk); pc_i = base + 32'(4 * i); #1;
      check($sformatf("%s grant%0d", name, i), {31'b0, instruction_grant}, 32'h1);
      check($sformatf("%s word%0d", name, i), instruction, mem_data(pc_i));
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        exp_grant;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cycles;
    vecs[0] = '{pc: 32'h108, exp_grant: 1'b1, exp_instr: 32'hA2};
    vecs[1] = '{pc: 32'h100, exp_grant: 1'b1, exp_instr: 32'hA0};
    vecs[2] = '{pc: 32'h10C, exp_grant: 1'b1, exp_instr: 32'hA3};
    vecs[3] = '{pc: 32'h106, exp_grant: 1'b1, exp_instr: 32'hA1};
    vecs[4] = '{pc: 32'h101, exp_grant: 1'b1, exp_instr: 32'hA0};
    vecs[5] = '{pc: 32'h104, exp_grant: 1'b1, exp_instr: 32'hA1};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst grant", {31'b0, instruction_grant}, 32'h0);
    check("rst instr", instruction, NOP);
    check("rst mem_en", {31'b0, mem_read_enable}, 32'h0);
    check("rst mem_addr", mem_address, 32'h0);

    // Cold miss on 0x100 starts at reset release.
    @(negedge clk); rst_n = 1'b1; #1;
    finish_miss(32'h100, 5, "cold");

    for (int i = 0; i < 6; i++) begin
      @(negedge clk); pc_i = vecs[i].pc; #1;
      check($sformatf("vec%0d grant", i), {31'b0, instruction_grant}, {31'b0, vecs[i].exp_grant});
      check($sformatf("vec%0d instr", i), instruction, vecs[i].exp_instr);
    end

    // Conflict eviction: 0x500 shares the index of 0x100.
    fetch_miss(32'h500, 5, "conflict");
    fetch_miss(32'h100, 5, "refetch");

    // Memory stall: three idle cycles before each word.
    stall_cycles = 3;
    fetch_miss(32'h400, 17, "stall");
    stall_cycles = 0;
    check_line(32'h400, "stall_line");

    // Invalidate during the second word of a refill.
    @(negedge clk); pc_i = 32'h200; #1;
    check("inv miss", {31'b0, instruction_grant}, 32'h0);
    @(negedge clk); #1;
    check("inv w0 addr", mem_address, 32'h200);
    @(negedge clk); invalidate = 1'b1; #1;
    check("inv w1 addr", mem_address, 32'h204);
    @(negedge clk); invalidate = 1'b0; #1;
    wait_mem_idle(50, "inv");
    check("inv line invalid", {31'b0, instruction_grant}, 32'h0);
    @(negedge clk); #1;
    check("inv rerefill en", {31'b0, mem_read_enable}, 32'h1);
    check("inv rerefill addr", mem_address, 32'h200);
    wait_grant(50, cycles);
    check("inv rerefill latency", cycles, 4);
    check("inv rerefill data", instruction, 32'hE0);
    fetch_miss(32'h100, 5, "inv_old_line");

    // PC change mid-refill.
    @(negedge clk); pc_i = 32'h300; #1;
    check("pcchg miss", {31'b0, instruction_grant}, 32'h0);
    addr_log.delete();
    @(negedge clk); #1;
    check("pcchg refilling no grant", {31'b0, instruction_grant}, 32'h0);
    @(negedge clk); pc_i = 32'h104; #1;
    check("pcchg hit grant", {31'b0, instruction_grant}, 32'h1);
    check("pcchg hit instr", instruction, 32'hA1);
    wait_mem_idle(50, "pcchg");
    check("pcchg n_words", addr_log.size(), WPL);
    @(negedge clk); pc_i = 32'h300; #1;
    check("pcchg return grant", {31'b0, instruction_grant}, 32'h1);
    check("pcchg return instr", instruction, 32'h120);

    // Invalidate while idle on a hitting PC.
    @(negedge clk); invalidate = 1'b1; #1;
    check("idle_inv still hit", {31'b0, instruction_grant}, 32'h1);
    @(negedge clk); invalidate = 1'b0; #1;
    finish_miss(32'h300, 5, "idle_inv");

    // Reset mid-refill.
    fetch_miss(32'h100, 5, "pre_rst");
    @(negedge clk); pc_i = 32'h600; #1;
    check("rstmid miss", {31'b0, instruction_grant}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); pc_i = 32'h100; #1;
    check("rstmid hit", {31'b0, instruction_grant}, 32'h1);
    check("rstmid addr", mem_address, 32'h608);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid en", {31'b0, mem_read_enable}, 32'h0);
    check("rstmid grant", {31'b0, instruction_grant}, 32'h0);
    check("rstmid instr", instruction, NOP);
    @(negedge clk); rst_n = 1'b1; #1;
    finish_miss(32'h100, 5, "post_rst");
    fetch_miss(32'h600, 5, "post_rst_partial");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
